// File: rtl/sd_mirror_fifo.sv
// Buffered mirrored fork: each accepted item goes to a masked subset of outputs,
// and each output drains a shared buffer independently of the others.
module sd_mirror_fifo #(
  parameter int mirror = 2,
  parameter int width  = 128,
  parameter int depth  = 4,
  parameter int asz    = $clog2(depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    c_srdy,
  output logic                    c_drdy,
  input  logic [width-1:0]        c_data,
  input  logic [mirror-1:0]       c_dst_vld,
  output logic [mirror-1:0]       p_srdy,
  input  logic [mirror-1:0]       p_drdy,
  output logic [mirror*width-1:0] p_data,
  output logic [asz:0]            usage
);

  localparam logic [asz:0] FullCount = (asz+1)'(depth);

  logic [width-1:0]  memData [depth];
  logic [mirror-1:0] pendQ   [depth];
  logic [mirror-1:0] pendD   [depth];
  logic [asz:0]      optrQ   [mirror];
  logic [asz:0]      optrD   [mirror];
  logic [asz-1:0]    outIdx  [mirror];
  logic [asz:0]      wrPtrQ, wrPtrD;
  logic [asz:0]      rdPtrQ, rdPtrD;
  logic [asz:0]      count;
  logic [mirror-1:0] outValid, outAdv, outXfer, outPastRd;
  logic [mirror-1:0] wrMask;
  logic              doWrite, doRetire;

  assign count   = wrPtrQ - rdPtrQ;
  assign usage   = count;
  assign c_drdy  = (count != FullCount);
  assign doWrite = c_srdy & c_drdy;
  assign wrMask  = (c_dst_vld == '0) ? '1 : c_dst_vld;

  // Each output walks its own pointer; entries not destined for it are skipped.
  for (genvar k = 0; k < mirror; k++) begin : g_out
    assign outIdx[k]                 = optrQ[k][asz-1:0];
    assign outValid[k]               = (optrQ[k] != wrPtrQ);
    assign p_srdy[k]                 = outValid[k] & pendQ[outIdx[k]][k];
    assign p_data[k*width +: width]  = memData[outIdx[k]];
    assign outXfer[k]                = p_srdy[k] & p_drdy[k];
    assign outAdv[k]                 = outValid[k] & (~pendQ[outIdx[k]][k] | p_drdy[k]);
    assign outPastRd[k]              = (optrQ[k] != rdPtrQ);
  end

  assign doRetire = (count != '0) && (pendQ[rdPtrQ[asz-1:0]] == '0) && (&outPastRd);

  always_comb begin
    pendD  = pendQ;
    wrPtrD = wrPtrQ + {{asz{1'b0}}, doWrite};
    rdPtrD = rdPtrQ + {{asz{1'b0}}, doRetire};
    for (int k = 0; k < mirror; k++) begin
      optrD[k] = optrQ[k] + {{asz{1'b0}}, outAdv[k]};
      if (outXfer[k]) pendD[outIdx[k]][k] = 1'b0;
    end
    // A write never lands on an entry still being read, since the buffer is not full.
    if (doWrite) pendD[wrPtrQ[asz-1:0]] = wrMask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      for (int k = 0; k < mirror; k++) optrQ[k] <= '0;
      for (int d = 0; d < depth; d++) pendQ[d] <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      for (int k = 0; k < mirror; k++) optrQ[k] <= optrD[k];
      for (int d = 0; d < depth; d++) pendQ[d] <= pendD[d];
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) memData[wrPtrQ[asz-1:0]] <= c_data;
  end

endmodule

// File: tb/tb_sd_mirror_fifo.sv
// Self-checking bench for sd_mirror_fifo: cycle tables for exact timing plus a
// per-output scoreboard that checks every delivered item for order and loss.
module tb_sd_mirror_fifo;
  localparam int MIRROR = 2;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int ASZ    = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    c_srdy = 1'b0;
  logic                    c_drdy;
  logic [WIDTH-1:0]        c_data = '0;
  logic [MIRROR-1:0]       c_dst_vld = '0;
  logic [MIRROR-1:0]       p_srdy;
  logic [MIRROR-1:0]       p_drdy = '0;
  logic [MIRROR*WIDTH-1:0] p_data;
  logic [ASZ:0]            usage;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] expQ0[$];
  logic [WIDTH-1:0] expQ1[$];

  typedef struct {
    logic             csrdy;
    logic [WIDTH-1:0] data;
    logic [1:0]       mask;
    logic [1:0]       pdrdy;
    logic             expCdrdy;
    logic [1:0]       expPsrdy;
    logic [ASZ:0]     expUsage;
  } vec_t;
  vec_t vecs[$];

  sd_mirror_fifo #(.mirror(MIRROR), .width(WIDTH), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .c_dst_vld(c_dst_vld), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .usage(usage)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic [WIDTH-1:0] d, input logic [1:0] m, input logic [1:0] pd);
    @(posedge clk);
    #1;
    c_srdy    = cs;
    c_data    = d;
    c_dst_vld = m;
    p_drdy    = pd;
  endtask

  task automatic addVec(input logic cs, input logic [WIDTH-1:0] d, input logic [1:0] m, input logic [1:0] pd,
                        input logic ec, input logic [1:0] ep, input logic [ASZ:0] eu);
    vec_t v;
    v.csrdy = cs; v.data = d; v.mask = m; v.pdrdy = pd;
    v.expCdrdy = ec; v.expPsrdy = ep; v.expUsage = eu;
    vecs.push_back(v);
  endtask

  // Inputs are stable at the falling edge, so handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] expData;
    logic [1:0]       m;
    if (reset) begin
      expQ0.delete();
      expQ1.delete();
    end else begin
      if (p_srdy[0] && p_drdy[0]) begin
        checkOutput("out0 item expected", 64'(expQ0.size() != 0), 64'd1);
        if (expQ0.size() != 0) begin
          expData = expQ0.pop_front();
          checkOutput("out0 data", 64'(p_data[WIDTH-1:0]), 64'(expData));
        end
      end
      if (p_srdy[1] && p_drdy[1]) begin
        checkOutput("out1 item expected", 64'(expQ1.size() != 0), 64'd1);
        if (expQ1.size() != 0) begin
          expData = expQ1.pop_front();
          checkOutput("out1 data", 64'(p_data[2*WIDTH-1:WIDTH]), 64'(expData));
        end
      end
      if (c_srdy && c_drdy) begin
        m = (c_dst_vld == 2'b00) ? 2'b11 : c_dst_vld;
        if (m[0]) expQ0.push_back(c_data);
        if (m[1]) expQ1.push_back(c_data);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit drained;
    // Full-buffer stall on output 1, refused write during a retire, then masked skips.
    addVec(1, 32'hA0, 2'b00, 2'b01, 1, 2'b00, 3'd0);
    addVec(1, 32'hA1, 2'b00, 2'b01, 1, 2'b11, 3'd1);
    addVec(1, 32'hA2, 2'b00, 2'b01, 1, 2'b11, 3'd2);
    addVec(1, 32'hA3, 2'b00, 2'b01, 1, 2'b11, 3'd3);
    addVec(1, 32'h44, 2'b00, 2'b01, 0, 2'b11, 3'd4);
    addVec(1, 32'h44, 2'b00, 2'b01, 0, 2'b10, 3'd4);
    addVec(1, 32'h44, 2'b00, 2'b11, 0, 2'b10, 3'd4);
    addVec(1, 32'h44, 2'b00, 2'b11, 0, 2'b10, 3'd4);
    addVec(1, 32'h44, 2'b00, 2'b11, 1, 2'b10, 3'd3);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b11, 3'd3);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b10, 3'd2);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b00, 3'd1);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b00, 3'd0);
    addVec(1, 32'hB1, 2'b01, 2'b11, 1, 2'b00, 3'd0);
    addVec(1, 32'hB2, 2'b10, 2'b11, 1, 2'b01, 3'd1);
    addVec(1, 32'hB3, 2'b11, 2'b11, 1, 2'b10, 3'd2);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b11, 3'd2);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b00, 3'd1);
    addVec(0, 32'h00, 2'b00, 2'b11, 1, 2'b00, 3'd0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset p_srdy", 64'(p_srdy), 64'd0);
    checkOutput("reset usage", 64'(usage), 64'd0);
    checkOutput("reset c_drdy", 64'(c_drdy), 64'd1);

    $display("[TB] streaming with both outputs ready");
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 2'b00, 2'b11);
      @(negedge clk);
      checkOutput("stream c_drdy", 64'(c_drdy), 64'd1);
      checkOutput("stream usage", 64'(usage), (i == 1) ? 64'd0 : (i == 2) ? 64'd1 : 64'd2);
      if (i == 2) checkOutput("stream first p_srdy", 64'(p_srdy), 64'd3);
    end
    repeat (6) applyStimulus(1'b0, '0, 2'b00, 2'b11);
    @(negedge clk);
    checkOutput("stream drained usage", 64'(usage), 64'd0);

    $display("[TB] cycle table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].csrdy, vecs[i].data, vecs[i].mask, vecs[i].pdrdy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d c_drdy", i), 64'(c_drdy), 64'(vecs[i].expCdrdy));
      checkOutput($sformatf("vec%0d p_srdy", i), 64'(p_srdy), 64'(vecs[i].expPsrdy));
      checkOutput($sformatf("vec%0d usage", i), 64'(usage), 64'(vecs[i].expUsage));
    end

    $display("[TB] fill/drain wraps with random backpressure");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 10; c++) begin
        applyStimulus(1'b1, $urandom, 2'($urandom_range(0, 3)), 2'b00);
        @(negedge clk);
        checkOutput("fill usage bound", 64'(usage <= 3'd4), 64'd1);
        checkOutput("fill c_drdy vs full", 64'(c_drdy), 64'(usage != 3'd4));
        if (usage == 3'd4) break;
      end
      checkOutput("fill reached full", 64'(usage), 64'd4);
      drained = 1'b0;
      for (int c = 0; c < 100; c++) begin
        applyStimulus(1'b0, '0, 2'b00, 2'($urandom_range(0, 3)));
        @(negedge clk);
        checkOutput("drain c_drdy vs full", 64'(c_drdy), 64'(usage != 3'd4));
        if (usage == 3'd0) begin
          drained = 1'b1;
          break;
        end
      end
      checkOutput("drain completed", 64'(drained), 64'd1);
    end
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      checkOutput("mixed usage bound", 64'(usage <= 3'd4), 64'd1);
      checkOutput("mixed c_drdy vs full", 64'(c_drdy), 64'(usage != 3'd4));
    end
    repeat (10) applyStimulus(1'b0, '0, 2'b00, 2'b11);
    @(negedge clk);
    checkOutput("mixed drained usage", 64'(usage), 64'd0);

    $display("[TB] reset with buffered items");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(32'hC0 + i), 2'b00, 2'b01);
    applyStimulus(1'b0, '0, 2'b00, 2'b01);
    @(negedge clk);
    checkOutput("pre-reset usage", 64'(usage), 64'd3);
    checkOutput("pre-reset out1 stalled", 64'(p_srdy[1]), 64'd1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    p_drdy = 2'b11;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset p_srdy", 64'(p_srdy), 64'd0);
    checkOutput("post-reset usage", 64'(usage), 64'd0);
    checkOutput("post-reset c_drdy", 64'(c_drdy), 64'd1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, '0, 2'b00, 2'b11);
      @(negedge clk);
      checkOutput("no stale item", 64'(p_srdy), 64'd0);
    end
    applyStimulus(1'b1, 32'hD1, 2'b10, 2'b11);
    applyStimulus(1'b0, '0, 2'b00, 2'b11);
    @(negedge clk);
    checkOutput("fresh item p_srdy", 64'(p_srdy), 64'd2);
    repeat (6) applyStimulus(1'b0, '0, 2'b00, 2'b11);
    @(negedge clk);
    checkOutput("final usage", 64'(usage), 64'd0);
    checkOutput("out0 nothing lost", 64'(expQ0.size()), 64'd0);
    checkOutput("out1 nothing lost", 64'(expQ1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
